// File: rtl/dr32e_data_bus_arbiter.sv
// Two-host round-robin arbiter onto one req/gnt/rvalid data port.
// An in-order owner FIFO routes each response back to the host that issued it.
module dr32e_data_bus_arbiter #(
    parameter bit          MemECC         = 1'b0,
    parameter int unsigned MemDataWidth   = MemECC ? 39 : 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                host_req_i,
    output logic [1:0]                host_gnt_o,
    output logic [1:0]                host_rvalid_o,
    output logic [1:0]                host_err_o,
    input  logic [63:0]               host_addr_i,
    input  logic [1:0]                host_we_i,
    input  logic [7:0]                host_be_i,
    input  logic [2*MemDataWidth-1:0] host_wdata_i,
    output logic [MemDataWidth-1:0]   host_rdata_o,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    input  logic                      data_rvalid_i,
    input  logic                      data_err_i,
    output logic [31:0]               data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [MemDataWidth-1:0]   data_wdata_o,
    input  logic [MemDataWidth-1:0]   data_rdata_i,
    output logic                      busy_o,
    output logic                      resp_orphan_o
);

    // state | meaning
    // IDLE  | round-robin winner chosen each cycle from live requests
    // HOLD  | request issued but not granted; locked to sel_q until grant or drop

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                    state_q;
    logic                      sel_q;
    logic                      rr_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           cnt_q;
    logic [MaxOutstanding-1:0] owner_q;

    logic sel;
    logic can_issue;
    logic push;
    logic pop;
    logic head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrLast) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        can_issue = (cnt_q < CntMax);
        if (state_q == HOLD) begin
            sel        = sel_q;
            data_req_o = host_req_i[sel_q];
        end else begin
            sel        = host_req_i[rr_q] ? rr_q : ~rr_q;
            data_req_o = can_issue & (|host_req_i);
        end
        push = data_req_o & data_gnt_i;
        // No bypass from a same-cycle pop: a full FIFO blocks issue for this cycle.
        pop  = data_rvalid_i & (cnt_q != '0);
        head = owner_q[rd_ptr_q];
    end

    assign host_gnt_o    = {push & sel, push & ~sel};
    assign host_rvalid_o = {pop & head, pop & ~head};
    assign host_err_o    = {pop & head & data_err_i, pop & ~head & data_err_i};
    assign host_rdata_o  = data_rdata_i;
    assign resp_orphan_o = data_rvalid_i & (cnt_q == '0);
    assign busy_o        = data_req_o | (cnt_q != '0);

    assign data_addr_o  = sel ? host_addr_i[63:32] : host_addr_i[31:0];
    assign data_we_o    = sel ? host_we_i[1] : host_we_i[0];
    assign data_be_o    = sel ? host_be_i[7:4] : host_be_i[3:0];
    assign data_wdata_o = sel ? host_wdata_i[2*MemDataWidth-1:MemDataWidth]
                              : host_wdata_i[MemDataWidth-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            rr_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            owner_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                rr_q              <= ~sel;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            case (state_q)
                IDLE: begin
                    if (data_req_o && !data_gnt_i) begin
                        sel_q   <= sel;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // A host withdrawing its request before grant simply releases the lock.
                    if (push || !host_req_i[sel_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dr32e_data_bus_arbiter.sv
// Directed bench for dr32e_data_bus_arbiter: grant order, HOLD lock, full FIFO,
// response routing and orphan responses, all against hand-computed values.
module tb_dr32e_data_bus_arbiter;

    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [1:0]    host_req_i;
    logic [1:0]    host_gnt_o;
    logic [1:0]    host_rvalid_o;
    logic [1:0]    host_err_o;
    logic [63:0]   host_addr_i;
    logic [1:0]    host_we_i;
    logic [7:0]    host_be_i;
    logic [2*DW-1:0] host_wdata_i;
    logic [DW-1:0] host_rdata_o;
    logic          data_req_o;
    logic          data_gnt_i;
    logic          data_rvalid_i;
    logic          data_err_i;
    logic [31:0]   data_addr_o;
    logic          data_we_o;
    logic [3:0]    data_be_o;
    logic [DW-1:0] data_wdata_o;
    logic [DW-1:0] data_rdata_i;
    logic          busy_o;
    logic          resp_orphan_o;

    int n_checks = 0;
    int n_errors = 0;

    dr32e_data_bus_arbiter dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_err_o    (host_err_o),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_wdata_i  (host_wdata_i),
        .host_rdata_o  (host_rdata_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_err_i    (data_err_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .busy_o        (busy_o),
        .resp_orphan_o (resp_orphan_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle of inputs, let combinational paths settle, check the control outputs.
    task automatic cyc(input string tag,
                       input logic [1:0] req, input logic gnt, input logic rv,
                       input logic err, input logic [31:0] rdata,
                       input logic e_req, input logic [1:0] e_gnt,
                       input logic [1:0] e_rv, input logic [1:0] e_err,
                       input logic e_busy, input logic e_orph);
        host_req_i    = req;
        data_gnt_i    = gnt;
        data_rvalid_i = rv;
        data_err_i    = err;
        data_rdata_i  = rdata;
        #1;
        chk({tag, " data_req"}, 64'(data_req_o), 64'(e_req));
        chk({tag, " host_gnt"}, 64'(host_gnt_o), 64'(e_gnt));
        chk({tag, " host_rvalid"}, 64'(host_rvalid_o), 64'(e_rv));
        chk({tag, " host_err"}, 64'(host_err_o), 64'(e_err));
        chk({tag, " busy"}, 64'(busy_o), 64'(e_busy));
        chk({tag, " orphan"}, 64'(resp_orphan_o), 64'(e_orph));
    endtask

    task automatic reset_pulse();
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni        = 1'b0;
        host_req_i    = 2'b00;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = '0;
        host_addr_i   = {32'h0000_1000, 32'h0000_0100};
        host_we_i     = 2'b10;
        host_be_i     = 8'hC3;
        host_wdata_i  = {32'h2222_2222, 32'h1111_1111};

        #1;
        chk("rst data_req", 64'(data_req_o), 64'd0);
        chk("rst host_gnt", 64'(host_gnt_o), 64'd0);
        chk("rst host_rvalid", 64'(host_rvalid_o), 64'd0);
        chk("rst host_err", 64'(host_err_o), 64'd0);
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst orphan", 64'(resp_orphan_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Single host-0 transaction, response two cycles after grant.
        cyc("t1a", 2'b01, 1, 0, 0, 32'h0, 1, 2'b01, 2'b00, 2'b00, 1, 0);
        chk("t1a addr", 64'(data_addr_o), 64'h100);
        tick();
        cyc("t1b", 2'b00, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
        tick();
        cyc("t1c", 2'b00, 0, 1, 0, 32'hDEADBEEF, 0, 2'b00, 2'b01, 2'b00, 1, 0);
        chk("t1c rdata", 64'(host_rdata_o), 64'hDEAD_BEEF);
        tick();
        cyc("t1d", 2'b00, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick();

        // Both hosts requesting, grant every cycle, responses keep the FIFO from filling.
        reset_pulse();
        cyc("t2c1", 2'b11, 1, 0, 0, 32'h0, 1, 2'b01, 2'b00, 2'b00, 1, 0);
        chk("t2c1 addr", 64'(data_addr_o), 64'h100);
        tick();
        cyc("t2c2", 2'b11, 1, 1, 0, 32'h0, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        chk("t2c2 addr", 64'(data_addr_o), 64'h1000);
        tick();
        cyc("t2c3", 2'b11, 1, 1, 0, 32'h0, 1, 2'b01, 2'b10, 2'b00, 1, 0);
        chk("t2c3 addr", 64'(data_addr_o), 64'h100);
        tick();
        cyc("t2c4", 2'b11, 1, 1, 0, 32'h0, 1, 2'b10, 2'b01, 2'b00, 1, 0);
        chk("t2c4 addr", 64'(data_addr_o), 64'h1000);
        tick();
        cyc("t2c5", 2'b00, 0, 1, 0, 32'h0, 0, 2'b00, 2'b10, 2'b00, 1, 0);
        tick();
        cyc("t2c6", 2'b00, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick();

        // HOLD lock on host 1, then host 0 next; then full FIFO and error routing.
        cyc("t3e1", 2'b01, 1, 0, 0, 32'h0, 1, 2'b01, 2'b00, 2'b00, 1, 0);
        tick();
        cyc("t3e2", 2'b11, 0, 1, 0, 32'h0, 1, 2'b00, 2'b01, 2'b00, 1, 0);
        chk("t3e2 addr", 64'(data_addr_o), 64'h1000);
        chk("t3e2 be", 64'(data_be_o), 64'hC);
        chk("t3e2 we", 64'(data_we_o), 64'd1);
        tick();
        cyc("t3e3", 2'b11, 0, 0, 0, 32'h0, 1, 2'b00, 2'b00, 2'b00, 1, 0);
        chk("t3e3 addr", 64'(data_addr_o), 64'h1000);
        tick();
        cyc("t3e4", 2'b11, 0, 0, 0, 32'h0, 1, 2'b00, 2'b00, 2'b00, 1, 0);
        chk("t3e4 addr", 64'(data_addr_o), 64'h1000);
        tick();
        cyc("t3e5", 2'b11, 1, 0, 0, 32'h0, 1, 2'b10, 2'b00, 2'b00, 1, 0);
        chk("t3e5 wdata", 64'(data_wdata_o), 64'h2222_2222);
        tick();
        cyc("t3e6", 2'b11, 1, 0, 0, 32'h0, 1, 2'b01, 2'b00, 2'b00, 1, 0);
        chk("t3e6 addr", 64'(data_addr_o), 64'h100);
        chk("t3e6 wdata", 64'(data_wdata_o), 64'h1111_1111);
        tick();
        cyc("t3e7", 2'b01, 1, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
        tick();
        cyc("t3e8", 2'b01, 1, 1, 1, 32'h0, 0, 2'b00, 2'b10, 2'b10, 1, 0);
        tick();
        cyc("t3e9", 2'b01, 1, 0, 0, 32'h0, 1, 2'b01, 2'b00, 2'b00, 1, 0);
        tick();
        cyc("t3e10", 2'b00, 0, 1, 0, 32'h0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
        tick();
        cyc("t3e11", 2'b00, 0, 1, 0, 32'h0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
        tick();

        // Host 0 drops its request while held: lock released, no grant, no push.
        cyc("t4h1", 2'b01, 0, 0, 0, 32'h0, 1, 2'b00, 2'b00, 2'b00, 1, 0);
        tick();
        cyc("t4h2", 2'b10, 1, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick();
        cyc("t4h3", 2'b00, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick();

        // Orphan responses: empty FIFO, and after a reset mid-transaction.
        cyc("t5o1", 2'b00, 0, 1, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        tick();
        cyc("t5o2", 2'b00, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick();
        cyc("t5o3", 2'b01, 1, 0, 0, 32'h0, 1, 2'b01, 2'b00, 2'b00, 1, 0);
        tick();
        reset_pulse();
        cyc("t5o4", 2'b00, 0, 1, 1, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        tick();
        cyc("t5o5", 2'b00, 0, 0, 0, 32'h0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
